mmio_csr_responder: RTL and testbench

//  Host-facing MMIO responder for the AFU. Decodes CCI-P MMIO read/write requests arriving on
//  RX channel c0 and drives the AFU feature header, ID and control/status registers. Returns

---
 rtl/afu_csr_pkg.sv | 79 +++++++
 rtl/mmio_csr_responder_if.sv | 16 +
 rtl/mmio_csr_responder.sv | 157 +++++++++++++++
 tb/tb_mmio_csr_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/afu_csr_pkg.sv
// rtl/afu_csr_pkg.sv - shared AFU CSR map, MMIO bus types and write-merge helper
//
// Purpose : register byte offsets, the DFH constant, the CTRL bit layout and the
//           reduced CCI-P MMIO request/response types used by the MMIO responder.
// Ports   : none (package).
// Config  : MMIO_CYCLE_CNT_EN - the CSR_CYCLE_CNT offset is only decoded when defined.

package afu_csr_pkg;

  // Byte offsets are the DWORD index shifted left by two.
  localparam int CSR_OFF_W = 18;
  typedef logic [CSR_OFF_W-1:0] t_csr_off;

  localparam t_csr_off CSR_DFH       = 18'h00;
  localparam t_csr_off CSR_ID_L      = 18'h08;
  localparam t_csr_off CSR_ID_H      = 18'h10;
  localparam t_csr_off CSR_SCRATCH   = 18'h28;
  localparam t_csr_off CSR_CTRL      = 18'h30;
  localparam t_csr_off CSR_BUF_ADDR  = 18'h38;
  localparam t_csr_off CSR_STATUS    = 18'h40;
  localparam t_csr_off CSR_CYCLE_CNT = 18'h48;

  // AFU type, end-of-list set, no next feature.
  localparam logic [63:0] CSR_DFH_VALUE = {4'h1, 8'h0, 4'h0, 7'h0, 1'b1, 24'h0, 16'h0};

  localparam logic [1:0] MMIO_LEN_4B = 2'b00;
  localparam logic [1:0] MMIO_LEN_8B = 2'b01;

  typedef struct packed {
    logic clear;   // bit 1
    logic start;   // bit 0
  } t_csr_ctrl;

  typedef struct packed {
    logic [15:0] address;  // DWORD index
    logic [1:0]  length;
    logic [8:0]  tid;
  } t_ccip_c0_req_mmio_hdr;

  typedef struct packed {
    t_ccip_c0_req_mmio_hdr hdr;
    logic [63:0]           data;
    logic                  mmio_rd_valid;
    logic                  mmio_wr_valid;
  } t_if_ccip_rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_rsp_mmio_hdr;

  typedef struct packed {
    t_ccip_c2_rsp_mmio_hdr hdr;
    logic                  mmio_rd_valid;
    logic [63:0]           data;
  } t_if_ccip_c2_tx;

  // Aligned 64-bit register offset addressed by a DWORD index.
  function automatic t_csr_off csr_word_off(input logic [15:0] dw_addr);
    return {dw_addr[15:1], 3'b000};
  endfunction

  // A 4B write carries its payload in data[31:0] and lands in the half picked by
  // address[0]; any other length replaces the whole register.
  function automatic logic [63:0] merge_write(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [1:0]  length,
                                              input logic        upper);
    logic [63:0] res;
    if (length != MMIO_LEN_4B) begin
      res = wdata;
    end else if (upper) begin
      res = {wdata[31:0], old_val[31:0]};
    end else begin
      res = {old_val[63:32], wdata[31:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_csr_responder_if.sv
// rtl/mmio_csr_responder_if.sv - MMIO request/response bundle between host side and responder
//
// Purpose : carries the c0 MMIO request channel (rx) and the c2 read response channel (tx_c2).
// Signals : rx    - request header, write data, read/write valids (host -> responder)
//           tx_c2 - read response tid, valid, data (responder -> host)
// Modports: master drives rx and observes tx_c2; slave observes rx and drives tx_c2.

interface mmio_csr_responder_if;
  import afu_csr_pkg::*;

  t_if_ccip_rx    rx;
  t_if_ccip_c2_tx tx_c2;

  modport master (output rx, input tx_c2);
  modport slave  (input rx, output tx_c2);
endinterface

// File: rtl/mmio_csr_responder.sv
// rtl/mmio_csr_responder.sv - AFU MMIO CSR decoder with a fixed two-cycle read pipeline
//
// Purpose : decodes MMIO reads/writes, holds SCRATCH/BUF_ADDR, pulses start/clear on CTRL
//           writes and returns read data two cycles after each accepted read.
// Ports   : clk      - rising-edge clock
//           rst_n    - asynchronous active-low reset
//           mmio     - slave side of mmio_csr_responder_if (rx request, tx_c2 response)
//           start    - one-cycle pulse after a CTRL write with bit0 set
//           clear    - one-cycle pulse after a CTRL write with bit1 set
//           buf_addr - BUF_ADDR register contents
//           busy     - AFU busy, read back in STATUS[0]
//           done     - AFU done, read back in STATUS[1]
// Config  : MMIO_CYCLE_CNT_EN - when defined, adds a free-running 64-bit cycle counter at 0x48
//           that any write to 0x48 zeroes; when undefined 0x48 is unmapped.

module mmio_csr_responder
  import afu_csr_pkg::*;
#(
  parameter logic [63:0] AFU_ID_L    = 64'h0,
  parameter logic [63:0] AFU_ID_H    = 64'h0,
  parameter logic [63:0] SCRATCH_RST = 64'h0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mmio_csr_responder_if.slave         mmio,
  output logic                        start,
  output logic                        clear,
  output logic [63:0]                 buf_addr,
  input  logic                        busy,
  input  logic                        done
);

  t_if_ccip_rx    rx;
  t_csr_off       req_off;
  logic           req_upper;

  logic [63:0]    scratch_q, scratch_d;
  logic [63:0]    buf_addr_q, buf_addr_d;
  t_csr_ctrl      ctrl_q, ctrl_d;

  logic [63:0]    rd_data;
  logic           s1_valid_q, s1_valid_d;
  logic [8:0]     s1_tid_q, s1_tid_d;
  logic [63:0]    s1_data_q, s1_data_d;
  t_if_ccip_c2_tx tx_q, tx_d;

`ifdef MMIO_CYCLE_CNT_EN
  logic [63:0]    cycle_cnt_q, cycle_cnt_d;
`endif

  assign rx        = mmio.rx;
  assign req_off   = csr_word_off(rx.hdr.address);
  assign req_upper = rx.hdr.address[0];

  // Register writes. CTRL defaults to zero every cycle, so its bits are single-cycle pulses.
  always_comb begin
    scratch_d  = scratch_q;
    buf_addr_d = buf_addr_q;
    ctrl_d     = '0;
    if (rx.mmio_wr_valid) begin
      case (req_off)
        CSR_SCRATCH:  scratch_d  = merge_write(scratch_q, rx.data, rx.hdr.length, req_upper);
        CSR_BUF_ADDR: buf_addr_d = merge_write(buf_addr_q, rx.data, rx.hdr.length, req_upper);
        CSR_CTRL: begin
          // A 4B write to the upper half of CTRL carries no start/clear bits.
          if (!(rx.hdr.length == MMIO_LEN_4B && req_upper)) begin
            ctrl_d = t_csr_ctrl'(rx.data[1:0]);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MMIO_CYCLE_CNT_EN
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 64'd1;
    if (rx.mmio_wr_valid && req_off == CSR_CYCLE_CNT) begin
      cycle_cnt_d = 64'h0;
    end
  end
`endif

  // Read mux, evaluated in the request cycle against the current register state. Muxing here
  // rather than one stage later means a read paired with a write in the same cycle returns
  // the pre-write value, while a write one cycle earlier is already visible.
  always_comb begin
    rd_data = 64'h0;
    case (req_off)
      CSR_DFH:       rd_data = CSR_DFH_VALUE;
      CSR_ID_L:      rd_data = AFU_ID_L;
      CSR_ID_H:      rd_data = AFU_ID_H;
      CSR_SCRATCH:   rd_data = scratch_q;
      CSR_BUF_ADDR:  rd_data = buf_addr_q;
      CSR_STATUS:    rd_data = {62'h0, done, busy};
`ifdef MMIO_CYCLE_CNT_EN
      CSR_CYCLE_CNT: rd_data = cycle_cnt_q;
`endif
      default:       rd_data = 64'h0;
    endcase
  end

  // Stage 1: capture the accepted read; idle slots carry zero tid/data.
  always_comb begin
    s1_valid_d = rx.mmio_rd_valid;
    s1_tid_d   = '0;
    s1_data_d  = 64'h0;
    if (rx.mmio_rd_valid) begin
      s1_tid_d  = rx.hdr.tid;
      s1_data_d = rd_data;
    end
  end

  // Stage 2: registered c2 response. No backpressure, so it simply follows stage 1.
  always_comb begin
    tx_d               = '0;
    tx_d.mmio_rd_valid = s1_valid_q;
    tx_d.hdr.tid       = s1_tid_q;
    tx_d.data          = s1_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q  <= SCRATCH_RST;
      buf_addr_q <= 64'h0;
      ctrl_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_tid_q   <= '0;
      s1_data_q  <= 64'h0;
      tx_q       <= '0;
    end else begin
      scratch_q  <= scratch_d;
      buf_addr_q <= buf_addr_d;
      ctrl_q     <= ctrl_d;
      s1_valid_q <= s1_valid_d;
      s1_tid_q   <= s1_tid_d;
      s1_data_q  <= s1_data_d;
      tx_q       <= tx_d;
    end
  end

`ifdef MMIO_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= 64'h0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end
`endif

  assign mmio.tx_c2 = tx_q;
  assign start      = ctrl_q.start;
  assign clear      = ctrl_q.clear;
  assign buf_addr   = buf_addr_q;

endmodule

// File: tb/tb_mmio_csr_responder.sv
// tb/tb_mmio_csr_responder.sv - directed vector bench for mmio_csr_responder

module tb_mmio_csr_responder;
  import afu_csr_pkg::*;

  localparam logic [63:0] ID_L    = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H    = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] SCR_RST = 64'h5A5A_0000_0000_A5A5;
  localparam logic [63:0] DFH_EXP = 64'h1000_0100_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy = 1'b0;
  logic        done = 1'b0;
  logic        start;
  logic        clear;
  logic [63:0] buf_addr;

  int errors = 0;
  int checks = 0;
  int start_pulses = 0;
  int clear_pulses = 0;

  always #5 clk = ~clk;

  mmio_csr_responder_if bus();

  mmio_csr_responder #(
    .AFU_ID_L   (ID_L),
    .AFU_ID_H   (ID_H),
    .SCRATCH_RST(SCR_RST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mmio    (bus),
    .start   (start),
    .clear   (clear),
    .buf_addr(buf_addr),
    .busy    (busy),
    .done    (done)
  );

  always @(negedge clk) begin
    if (start) start_pulses++;
    if (clear) clear_pulses++;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  len;
    logic [15:0] addr;
    logic [8:0]  tid;
    logic [63:0] wdata;
    logic        busy;
    logic        done;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic t_if_ccip_rx mk(input logic rd, input logic wr, input logic [15:0] addr,
                                     input logic [1:0] len, input logic [8:0] tid,
                                     input logic [63:0] data);
    t_if_ccip_rx r;
    r.hdr.address    = addr;
    r.hdr.length     = len;
    r.hdr.tid        = tid;
    r.data           = data;
    r.mmio_rd_valid  = rd;
    r.mmio_wr_valid  = wr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input string name, input logic [8:0] tid, input logic [63:0] data);
    chk({name, "_valid"}, 64'(bus.tx_c2.mmio_rd_valid), 64'h1);
    chk({name, "_tid"}, 64'(bus.tx_c2.hdr.tid), 64'(tid));
    chk({name, "_data"}, bus.tx_c2.data, data);
  endtask

  task automatic expect_idle(input string name);
    chk({name, "_no_valid"}, 64'(bus.tx_c2.mmio_rd_valid), 64'h0);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [8:0] tid);
    bus.rx = mk(1'b1, 1'b0, addr, MMIO_LEN_8B, tid, 64'h0);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [1:0] len, input logic [63:0] data);
    bus.rx = mk(1'b0, 1'b1, addr, len, 9'h0, data);
  endtask

  task automatic idle();
    bus.rx = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", idx);
    bus.rx = mk(v.rd, v.wr, v.addr, v.len, v.tid, v.wdata);
    busy = v.busy;
    done = v.done;
    step();
    idle();
    expect_idle({nm, "_p1"});
    step();
    if (v.rd) expect_rsp(nm, v.tid, v.exp);
    else      expect_idle({nm, "_p2"});
  endtask

  initial begin
    int seen;
    // rd, wr, len, dword addr, tid, wdata, busy, done, expected read data
    vecs.push_back('{0, 1, MMIO_LEN_8B, 16'h0E, 9'h00, 64'h0000_0001_2345_6000, 0, 0, 64'h0});
    vecs.push_back('{1, 0, MMIO_LEN_8B, 16'h0E, 9'h10, 64'h0, 0, 0, 64'h0000_0001_2345_6000});
    vecs.push_back('{0, 1, MMIO_LEN_4B, 16'h0E, 9'h00, 64'h9999_9999_AAAA_BBBB, 0, 0, 64'h0});
    vecs.push_back('{1, 0, MMIO_LEN_4B, 16'h0F, 9'h11, 64'h0, 0, 0, 64'h0000_0001_AAAA_BBBB});
    vecs.push_back('{1, 0, MMIO_LEN_8B, 16'h06, 9'h12, 64'h0, 0, 0, 64'h0});
    vecs.push_back('{1, 0, MMIO_LEN_8B, 16'h08, 9'h13, 64'h0, 0, 0, 64'h0});
    vecs.push_back('{1, 0, MMIO_LEN_8B, 16'h0C, 9'h14, 64'h0, 0, 0, 64'h0});
    vecs.push_back('{1, 0, MMIO_LEN_8B, 16'h10, 9'h15, 64'h0, 1, 0, 64'h1});
    vecs.push_back('{1, 0, MMIO_LEN_8B, 16'h10, 9'h16, 64'h0, 0, 1, 64'h2});
    vecs.push_back('{0, 1, MMIO_LEN_8B, 16'h10, 9'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 64'h0});
    vecs.push_back('{1, 0, MMIO_LEN_8B, 16'h10, 9'h17, 64'h0, 1, 1, 64'h3});
    vecs.push_back('{1, 0, MMIO_LEN_8B, 16'h40, 9'h18, 64'h0, 0, 0, 64'h0});
    vecs.push_back('{0, 1, MMIO_LEN_8B, 16'h00, 9'h00, 64'hFF, 0, 0, 64'h0});
    vecs.push_back('{1, 0, MMIO_LEN_8B, 16'h00, 9'h19, 64'h0, 0, 0, DFH_EXP});
    vecs.push_back('{0, 1, MMIO_LEN_8B, 16'h02, 9'h00, 64'h0, 0, 0, 64'h0});
    vecs.push_back('{1, 0, MMIO_LEN_4B, 16'h03, 9'h1A, 64'h0, 0, 0, ID_L});
`ifndef MMIO_CYCLE_CNT_EN
    vecs.push_back('{1, 0, MMIO_LEN_8B, 16'h12, 9'h1B, 64'h0, 0, 0, 64'h0});
`endif

    idle();
    step();
    step();
    chk("rst_valid", 64'(bus.tx_c2.mmio_rd_valid), 64'h0);
    chk("rst_tid", 64'(bus.tx_c2.hdr.tid), 64'h0);
    chk("rst_data", bus.tx_c2.data, 64'h0);
    chk("rst_start", 64'(start), 64'h0);
    chk("rst_clear", 64'(clear), 64'h0);
    chk("rst_buf_addr", buf_addr, 64'h0);
    rst_n = 1'b1;
    step();

    // Back-to-back reads of DFH, ID_L, ID_H.
    rd(16'h00, 9'd3);
    step();
    expect_idle("b2b_lat1");
    rd(16'h02, 9'd4);
    step();
    expect_rsp("b2b_dfh", 9'd3, DFH_EXP);
    rd(16'h04, 9'd5);
    step();
    expect_rsp("b2b_id_l", 9'd4, ID_L);
    idle();
    step();
    expect_rsp("b2b_id_h", 9'd5, ID_H);
    step();
    expect_idle("b2b_end");

    // Write then read in the very next cycle.
    wr(16'h0A, MMIO_LEN_8B, 64'hDEAD_BEEF_CAFE_F00D);
    step();
    rd(16'h0A, 9'd9);
    step();
    idle();
    step();
    expect_rsp("wr_rd_8b", 9'd9, 64'hDEAD_BEEF_CAFE_F00D);

    wr(16'h0B, MMIO_LEN_4B, 64'hFFFF_FFFF_1234_5678);
    step();
    rd(16'h0A, 9'd10);
    step();
    idle();
    step();
    expect_rsp("wr_rd_4b_hi", 9'd10, 64'h1234_5678_CAFE_F00D);

    // CTRL pulses.
    wr(16'h0C, MMIO_LEN_8B, 64'h3);
    step();
    idle();
    chk("ctrl3_start", 64'(start), 64'h1);
    chk("ctrl3_clear", 64'(clear), 64'h1);
    step();
    chk("ctrl3_start_drop", 64'(start), 64'h0);
    chk("ctrl3_clear_drop", 64'(clear), 64'h0);
    wr(16'h0C, MMIO_LEN_4B, 64'h1);
    step();
    idle();
    chk("ctrl1_start", 64'(start), 64'h1);
    chk("ctrl1_clear", 64'(clear), 64'h0);
    step();
    chk("ctrl1_start_drop", 64'(start), 64'h0);

    // Simultaneous read and write: read sees the old value.
    bus.rx = mk(1'b1, 1'b1, 16'h0A, MMIO_LEN_8B, 9'h1AB, 64'h1111_2222_3333_4444);
    step();
    idle();
    step();
    expect_rsp("rdwr_old", 9'h1AB, 64'h1234_5678_CAFE_F00D);
    rd(16'h0A, 9'h0F);
    step();
    idle();
    step();
    expect_rsp("rdwr_new", 9'h0F, 64'h1111_2222_3333_4444);

    foreach (vecs[i]) run_vec(i, vecs[i]);
    busy = 1'b0;
    done = 1'b0;
    chk("buf_addr_out", buf_addr, 64'h0000_0001_AAAA_BBBB);

    // Reset while a read is in flight.
    rd(16'h0E, 9'h55);
    step();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.tx_c2.mmio_rd_valid) seen++;
    end
    chk("rst_flight_no_rsp", 64'(seen), 64'h0);
    chk("rst2_buf_addr", buf_addr, 64'h0);
    rd(16'h0A, 9'h21);
    step();
    idle();
    step();
    expect_rsp("rst2_scratch", 9'h21, SCR_RST);
    rd(16'h0E, 9'h22);
    step();
    idle();
    step();
    expect_rsp("rst2_buf_rd", 9'h22, 64'h0);

    step();
    chk("start_pulse_total", 64'(start_pulses), 64'd2);
    chk("clear_pulse_total", 64'(clear_pulses), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
